// File: rtl/bip_control_unit_if.sv
// Signal bundle between the BIP control unit, its program/data memories,
// the accumulator/ALU datapath and the debug unit.
interface bip_control_unit_if #(
  parameter int NBITS_D       = 16,
  parameter int NBITS_OPERAND = 11,
  parameter int NBITS_PC      = 11,
  parameter int NBITS_CNT     = 16
);
  // No valid/ready pairs here: program memory answers one cycle after o_PC
  // changes, data memory answers one cycle after o_RdRam, and i_enable is a
  // level permit that is only looked at while the unit waits in FETCH.
  logic                     i_enable;
  logic [NBITS_D-1:0]       i_instruction;
  logic [NBITS_PC-1:0]      o_PC;
  logic [NBITS_OPERAND-1:0] o_operand;
  logic [1:0]               o_SelA;
  logic                     o_SelB;
  logic                     o_Op;
  logic                     o_WrAcc;
  logic                     o_RdRam;
  logic                     o_WrRam;
  logic                     o_halt;
  logic [NBITS_CNT-1:0]     o_cycles;
  logic [2:0]               o_state;

  modport master (
    input  i_enable, i_instruction,
    output o_PC, o_operand, o_SelA, o_SelB, o_Op, o_WrAcc, o_RdRam, o_WrRam,
           o_halt, o_cycles, o_state
  );

  modport slave (
    output i_enable, i_instruction,
    input  o_PC, o_operand, o_SelA, o_SelB, o_Op, o_WrAcc, o_RdRam, o_WrRam,
           o_halt, o_cycles, o_state
  );
endinterface

// File: rtl/bip_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/HALT sequencer for the accumulator BIP.
// Owns the PC and IR; all datapath strobes are Moore outputs of state+IR.
module bip_control_unit #(
  parameter int NBITS_D       = 16,
  parameter int NBITS_OPCODE  = 5,
  parameter int NBITS_OPERAND = 11,
  parameter int NBITS_PC      = 11,
  parameter int NBITS_CNT     = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  bip_control_unit_if.master    bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [NBITS_OPCODE-1:0] OP_HLT  = 5'b00000;
  localparam logic [NBITS_OPCODE-1:0] OP_STO  = 5'b00001;
  localparam logic [NBITS_OPCODE-1:0] OP_LD   = 5'b00010;
  localparam logic [NBITS_OPCODE-1:0] OP_LDI  = 5'b00011;
  localparam logic [NBITS_OPCODE-1:0] OP_ADD  = 5'b00100;
  localparam logic [NBITS_OPCODE-1:0] OP_ADDI = 5'b00101;
  localparam logic [NBITS_OPCODE-1:0] OP_SUB  = 5'b00110;
  localparam logic [NBITS_OPCODE-1:0] OP_SUBI = 5'b00111;

  state_t                  state, next_state;
  logic [NBITS_D-1:0]      ir;
  logic [NBITS_PC-1:0]     pc;
  logic [NBITS_CNT-1:0]    cycles;
  logic [NBITS_OPCODE-1:0] ir_op, fetched_op;
  logic                    pc_inc, cnt_en;
  logic [1:0]              sel_a;
  logic                    sel_b, alu_op, wr_acc, rd_ram, wr_ram;

  assign ir_op      = ir[NBITS_D-1 -: NBITS_OPCODE];
  assign fetched_op = bus.i_instruction[NBITS_D-1 -: NBITS_OPCODE];

  // A FETCH cycle without permission is a stall and is not counted.
  assign cnt_en = (state != S_HALT) && !((state == S_FETCH) && !bus.i_enable);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state  <= S_FETCH;
      ir     <= '0;
      pc     <= '0;
      cycles <= '0;
    end else begin
      state <= next_state;
      if (state == S_DECODE) ir <= bus.i_instruction;
      if (pc_inc) pc <= pc + {{(NBITS_PC-1){1'b0}}, 1'b1};
      if (cnt_en && (cycles != {NBITS_CNT{1'b1}}))
        cycles <= cycles + {{(NBITS_CNT-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    next_state = state;
    pc_inc     = 1'b0;
    sel_a      = 2'd0;
    sel_b      = 1'b0;
    alu_op     = 1'b0;
    wr_acc     = 1'b0;
    rd_ram     = 1'b0;
    wr_ram     = 1'b0;
    case (state)
      S_FETCH: if (bus.i_enable) next_state = S_DECODE;
      S_DECODE: next_state = (fetched_op == OP_HLT) ? S_HALT : S_EXEC;
      S_EXEC: begin
        next_state = S_FETCH;
        pc_inc     = 1'b1;
        case (ir_op)
          OP_STO: wr_ram = 1'b1;
          OP_LDI: begin
            sel_a  = 2'd1;
            wr_acc = 1'b1;
          end
          OP_ADDI, OP_SUBI: begin
            sel_b  = 1'b1;
            sel_a  = 2'd2;
            alu_op = (ir_op == OP_SUBI);
            wr_acc = 1'b1;
          end
          // Memory operands need the read data, which arrives in MEM.
          OP_LD, OP_ADD, OP_SUB: begin
            rd_ram     = 1'b1;
            pc_inc     = 1'b0;
            next_state = S_MEM;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        next_state = S_FETCH;
        pc_inc     = 1'b1;
        wr_acc     = 1'b1;
        if (ir_op != OP_LD) begin
          sel_a  = 2'd2;
          alu_op = (ir_op == OP_SUB);
        end
      end
      S_HALT: ;
      default: next_state = S_FETCH;
    endcase
  end

  assign bus.o_PC      = pc;
  assign bus.o_operand = ir[NBITS_OPERAND-1:0];
  assign bus.o_SelA    = sel_a;
  assign bus.o_SelB    = sel_b;
  assign bus.o_Op      = alu_op;
  assign bus.o_WrAcc   = wr_acc;
  assign bus.o_RdRam   = rd_ram;
  assign bus.o_WrRam   = wr_ram;
  assign bus.o_halt    = (state == S_HALT);
  assign bus.o_cycles  = cycles;
  assign bus.o_state   = state;

endmodule
